// File: rtl/pellet_spawn_ctrl.sv
// pellet_spawn_ctrl
// Control side of the pellet spawner. Draws pseudo-random candidate
// coordinates from a free-running LFSR, asks the coordinate datapath to
// validate in-range candidates, and once a legal cell is committed paints
// the 5x5 pellet through the VGA plot port. When Pac-Man's top-left corner
// lands on the pellet's top-left corner the pellet is erased and a fresh
// spawn starts without any external request.

module pellet_spawn_ctrl #(
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter int unsigned X_MAX         = 155,
  parameter int unsigned Y_MAX         = 115,
  parameter int unsigned MAX_TRIES     = 64,
  parameter logic [2:0]  PELLET_COLOUR = 3'b110
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       spawn_req,
  input  logic [7:0] pacman_x,
  input  logic [6:0] pacman_y,
  output logic       new_coord,
  output logic [7:0] rand_x,
  output logic [6:0] rand_y,
  input  logic       valid_coord,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  output logic       plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       pellet_live,
  output logic [7:0] pellet_x,
  output logic [6:0] pellet_y,
  output logic       eaten,
  output logic       spawn_fail,
  output logic       busy
);

  localparam int unsigned     TW        = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0]   TRY_LIMIT = TW'(MAX_TRIES);
  localparam logic [7:0]      X_LIM     = 8'(X_MAX);
  localparam logic [6:0]      Y_LIM     = 7'(Y_MAX);
  localparam logic [2:0]      SWEEP_END = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_REQ,
    S_CHECK,
    S_DRAW,
    S_LIVE,
    S_ERASE
  } state_t;

  state_t          state_q, state_d;

  logic [15:0]     lfsr_q, lfsr_d;
  logic [TW-1:0]   tries_q, tries_d;
  logic [7:0]      rand_x_q, rand_x_d;
  logic [6:0]      rand_y_q, rand_y_d;
  logic [7:0]      pellet_x_q, pellet_x_d;
  logic [6:0]      pellet_y_q, pellet_y_d;
  logic [2:0]      col_q, col_d;
  logic [2:0]      row_q, row_d;
  logic            live_q, live_d;
  logic            eaten_q, eaten_d;
  logic            fail_q, fail_d;

  logic            lfsr_fb;
  logic [7:0]      cand_x;
  logic [6:0]      cand_y;
  logic            cand_ok;
  logic [TW-1:0]   tries_inc;
  logic            gen_give_up;
  logic            chk_give_up;
  logic            sweep_last;
  logic [2:0]      col_nx;
  logic [2:0]      row_nx;
  logic            pac_hit;

  // Shared decode terms used by the FSM and the datapath registers
  always_comb begin
    lfsr_fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    cand_x      = lfsr_q[7:0];
    cand_y      = lfsr_q[14:8];
    cand_ok     = (cand_x <= X_LIM) && (cand_y <= Y_LIM);
    tries_inc   = tries_q + TW'(1);
    // GEN judges the try limit on the count including the candidate being
    // drawn this cycle; CHECK sees the count already bumped by its GEN.
    gen_give_up = !cand_ok && (tries_inc == TRY_LIMIT);
    chk_give_up = !valid_coord && (tries_q == TRY_LIMIT);
    sweep_last  = (col_q == SWEEP_END) && (row_q == SWEEP_END);
    pac_hit     = (pacman_x == pellet_x_q) && (pacman_y == pellet_y_q);
    col_nx      = col_q + 3'd1;
    row_nx      = row_q;
    if (sweep_last) begin
      col_nx = '0;
      row_nx = '0;
    end else if (col_q == SWEEP_END) begin
      col_nx = '0;
      row_nx = row_q + 3'd1;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (spawn_req) begin
          state_d = S_GEN;
        end
      end
      S_GEN: begin
        if (cand_ok) begin
          state_d = S_REQ;
        end else if (gen_give_up) begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (valid_coord) begin
          state_d = S_DRAW;
        end else if (chk_give_up) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GEN;
        end
      end
      S_DRAW: begin
        if (sweep_last) begin
          state_d = S_LIVE;
        end
      end
      S_LIVE: begin
        if (pac_hit) begin
          state_d = S_ERASE;
        end
      end
      S_ERASE: begin
        if (sweep_last) begin
          state_d = S_GEN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the current state and pixel counters
  always_comb begin
    new_coord = 1'b0;
    plot      = 1'b0;
    vga_x     = '0;
    vga_y     = '0;
    colour    = '0;
    busy      = (state_q != S_IDLE) && (state_q != S_LIVE);
    case (state_q)
      S_REQ: begin
        new_coord = 1'b1;
      end
      S_DRAW: begin
        plot   = 1'b1;
        vga_x  = pellet_x_q + {5'd0, col_q};
        vga_y  = pellet_y_q + {4'd0, row_q};
        colour = PELLET_COLOUR;
      end
      S_ERASE: begin
        plot   = 1'b1;
        vga_x  = pellet_x_q + {5'd0, col_q};
        vga_y  = pellet_y_q + {4'd0, row_q};
        colour = '0;
      end
      default: begin
      end
    endcase
  end

  // Next values for the LFSR, try counter, coordinates, sweep and flags
  always_comb begin
    lfsr_d     = {lfsr_q[14:0], lfsr_fb};
    tries_d    = tries_q;
    rand_x_d   = rand_x_q;
    rand_y_d   = rand_y_q;
    pellet_x_d = pellet_x_q;
    pellet_y_d = pellet_y_q;
    col_d      = col_q;
    row_d      = row_q;
    live_d     = live_q;
    eaten_d    = 1'b0;
    fail_d     = fail_q;
    case (state_q)
      S_IDLE: begin
        if (spawn_req) begin
          tries_d = '0;
          fail_d  = 1'b0;
        end
      end
      S_GEN: begin
        rand_x_d = cand_x;
        rand_y_d = cand_y;
        tries_d  = tries_inc;
        if (gen_give_up) begin
          fail_d = 1'b1;
          live_d = 1'b0;
        end
      end
      S_CHECK: begin
        if (valid_coord) begin
          pellet_x_d = x_in;
          pellet_y_d = y_in;
          col_d      = '0;
          row_d      = '0;
        end else if (chk_give_up) begin
          fail_d = 1'b1;
          live_d = 1'b0;
        end
      end
      S_DRAW: begin
        col_d = col_nx;
        row_d = row_nx;
        if (sweep_last) begin
          live_d = 1'b1;
        end
      end
      S_LIVE: begin
        if (pac_hit) begin
          eaten_d = 1'b1;
          live_d  = 1'b0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_ERASE: begin
        col_d = col_nx;
        row_d = row_nx;
        if (sweep_last) begin
          tries_d = '0;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lfsr_q     <= SEED;
      tries_q    <= '0;
      rand_x_q   <= '1;
      rand_y_q   <= '1;
      pellet_x_q <= '1;
      pellet_y_q <= '1;
      col_q      <= '0;
      row_q      <= '0;
      live_q     <= 1'b0;
      eaten_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      tries_q    <= tries_d;
      rand_x_q   <= rand_x_d;
      rand_y_q   <= rand_y_d;
      pellet_x_q <= pellet_x_d;
      pellet_y_q <= pellet_y_d;
      col_q      <= col_d;
      row_q      <= row_d;
      live_q     <= live_d;
      eaten_q    <= eaten_d;
      fail_q     <= fail_d;
    end
  end

  assign rand_x      = rand_x_q;
  assign rand_y      = rand_y_q;
  assign pellet_x    = pellet_x_q;
  assign pellet_y    = pellet_y_q;
  assign pellet_live = live_q;
  assign eaten       = eaten_q;
  assign spawn_fail  = fail_q;

endmodule
